// File: rtl/data_bus_arbiter_if.sv
// Per-master request/response bundle for data_bus_arbiter.
// Signals:
//   req      master -> arbiter  transaction request
//   lock     master -> arbiter  hold the grant across following cycles (CPU only)
//   addr     master -> arbiter  address
//   wdata    master -> arbiter  write data
//   wenable  master -> arbiter  byte write enables, all zero means read
//   gnt      arbiter -> master  transaction accepted this cycle
//   rvalid   arbiter -> master  read data valid
//   rdata    arbiter -> master  read data
// Modports ending in _nl are for a master without a lock input.
interface data_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              req;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   wenable;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master   (output req, lock, addr, wdata, wenable, input  gnt, rvalid, rdata);
    modport slave    (input  req, lock, addr, wdata, wenable, output gnt, rvalid, rdata);
    modport master_nl(output req, addr, wdata, wenable,       input  gnt, rvalid, rdata);
    modport slave_nl (input  req, addr, wdata, wenable,       output gnt, rvalid, rdata);
endinterface

// File: rtl/data_bus_arbiter.sv
// Two-master, one-slave round-robin arbiter for the shared data-RAM/MMIO port.
// Master 0 (CPU) may lock the port for atomic read-modify-write; the lock is
// forcibly released after LOCK_MAX consecutive CPU grants.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   m0             CPU port (with lock)
//   m1             secondary master port (no lock)
//   s_addr/s_wdata/s_wenable/s_ren  slave request, driven by the granted master
//   s_rdata        slave read data, valid one cycle after s_ren
//   conflict_cnt   saturating count of cycles in which a requester was refused
module data_bus_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LOCK_MAX = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    data_bus_arbiter_if.slave     m0,
    data_bus_arbiter_if.slave_nl  m1,
    output logic [ADDR_W-1:0]     s_addr,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wenable,
    output logic                  s_ren,
    input  logic [DATA_W-1:0]     s_rdata,
    output logic [CNT_W-1:0]      conflict_cnt
);
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned LCNT_W = $clog2(LOCK_MAX) + 1;
    // Locked-cycle count at which the lock is dropped; the locking grant itself
    // precedes the locked cycles, so LOCK_MAX grants in total.
    localparam int unsigned REL_AT = (LOCK_MAX > 1) ? (LOCK_MAX - 2) : 0;

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;   // 1: master 1 was granted last
    logic [LCNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              gnt0_c, gnt1_c;
    logic              rd0_c, rd1_c;
    logic              conflict_c;

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_OPEN;
            last_gnt_q   <= 1'b1;
            lock_cnt_q   <= '0;
            conflict_cnt <= '0;
            m0.rvalid    <= 1'b0;
            m1.rvalid    <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            lock_cnt_q <= lock_cnt_d;
            m0.rvalid  <= rd0_c;
            m1.rvalid  <= rd1_c;
            if (conflict_c && (conflict_cnt != {CNT_W{1'b1}})) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

    // Grant decision, lock tracking and round-robin pointer
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        lock_cnt_d = lock_cnt_q;
        gnt0_c     = 1'b0;
        gnt1_c     = 1'b0;

        if (rst_n) begin
            case (state_q)
                ST_LOCKED: gnt0_c = m0.req;
                default: begin
                    if (m0.req && m1.req) begin
                        gnt0_c = last_gnt_q;
                        gnt1_c = !last_gnt_q;
                    end else begin
                        gnt0_c = m0.req;
                        gnt1_c = m1.req;
                    end
                end
            endcase
        end

        if (gnt0_c) begin
            last_gnt_d = 1'b0;
        end else if (gnt1_c) begin
            last_gnt_d = 1'b1;
        end

        case (state_q)
            ST_LOCKED: begin
                if (lock_cnt_q == LCNT_W'(REL_AT)) begin
                    // Forced release hands the next contention to master 1
                    state_d    = ST_OPEN;
                    lock_cnt_d = '0;
                    last_gnt_d = 1'b0;
                end else if (gnt0_c && !m0.lock) begin
                    state_d    = ST_OPEN;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + LCNT_W'(1);
                end
            end
            default: begin
                if (gnt0_c && m0.lock) begin
                    state_d    = ST_LOCKED;
                    lock_cnt_d = '0;
                end
            end
        endcase
    end

    // Slave port mux, read tracking and contention detect
    always_comb begin
        s_addr    = '0;
        s_wdata   = '0;
        s_wenable = '0;
        if (gnt0_c) begin
            s_addr    = m0.addr;
            s_wdata   = m0.wdata;
            s_wenable = m0.wenable;
        end else if (gnt1_c) begin
            s_addr    = m1.addr;
            s_wdata   = m1.wdata;
            s_wenable = m1.wenable;
        end
        rd0_c      = gnt0_c && (m0.wenable == BE_W'(0));
        rd1_c      = gnt1_c && (m1.wenable == BE_W'(0));
        s_ren      = rd0_c || rd1_c;
        conflict_c = (m0.req && !gnt0_c) || (m1.req && !gnt1_c);
    end

    assign m0.gnt   = gnt0_c;
    assign m1.gnt   = gnt1_c;
    assign m0.rdata = s_rdata;
    assign m1.rdata = s_rdata;
endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed-vector bench for data_bus_arbiter (LOCK_MAX=4, CNT_W=4).
module tb_data_bus_arbiter;
    logic        clk;
    logic        rst_n;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wenable;
    logic        s_ren;
    logic [31:0] s_rdata;
    logic [3:0]  conflict_cnt;

    data_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
    data_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();

    data_bus_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .LOCK_MAX(4),
        .CNT_W   (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m0          (m0_if),
        .m1          (m1_if),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_wenable   (s_wenable),
        .s_ren       (s_ren),
        .s_rdata     (s_rdata),
        .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        req0;
        logic        lock0;
        logic [31:0] addr0;
        logic [31:0] wd0;
        logic [3:0]  we0;
        logic        req1;
        logic [31:0] addr1;
        logic [31:0] wd1;
        logic [3:0]  we1;
        logic [31:0] srd;
        logic        g0;
        logic        g1;
        logic        ren;
        logic [31:0] saddr;
        logic [31:0] swd;
        logic [3:0]  swe;
        logic        rv0;
        logic        rv1;
        logic [3:0]  cnt;
    } vec_t;

    localparam int NV = 27;
    vec_t vt[NV];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n         = v.rst_n;
        m0_if.req     = v.req0;
        m0_if.lock    = v.lock0;
        m0_if.addr    = v.addr0;
        m0_if.wdata   = v.wd0;
        m0_if.wenable = v.we0;
        m1_if.req     = v.req1;
        m1_if.addr    = v.addr1;
        m1_if.wdata   = v.wd1;
        m1_if.wenable = v.we1;
        s_rdata       = v.srd;
    endtask

    task automatic idle();
        m0_if.req     = 1'b0;
        m0_if.lock    = 1'b0;
        m0_if.addr    = '0;
        m0_if.wdata   = '0;
        m0_if.wenable = '0;
        m1_if.req     = 1'b0;
        m1_if.addr    = '0;
        m1_if.wdata   = '0;
        m1_if.wenable = '0;
        s_rdata       = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int got;

        // rst, req0,lock0,addr0,wd0,we0, req1,addr1,wd1,we1, srd, g0,g1,ren, saddr,swd,swe, rv0,rv1,cnt
        vt[0]  = '{1'b0, 1'b1,1'b0,32'h100,32'h0,4'h0, 1'b1,32'h200,32'h0,4'h0, 32'h0, 1'b0,1'b0,1'b0, 32'h0,32'h0,4'h0, 1'b0,1'b0,4'd0};
        vt[1]  = '{1'b1, 1'b1,1'b0,32'h1000_0000,32'h41,4'hF, 1'b0,32'h0,32'h0,4'h0, 32'h0, 1'b1,1'b0,1'b0, 32'h1000_0000,32'h41,4'hF, 1'b0,1'b0,4'd0};
        vt[2]  = '{1'b1, 1'b1,1'b0,32'h40,32'h0,4'h0, 1'b0,32'h0,32'h0,4'h0, 32'h0, 1'b1,1'b0,1'b1, 32'h40,32'h0,4'h0, 1'b0,1'b0,4'd0};
        vt[3]  = '{1'b1, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,32'h0,4'h0, 32'hDEAD_BEEF, 1'b0,1'b0,1'b0, 32'h0,32'h0,4'h0, 1'b1,1'b0,4'd0};
        vt[4]  = '{1'b0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,32'h0,4'h0, 32'h0, 1'b0,1'b0,1'b0, 32'h0,32'h0,4'h0, 1'b0,1'b0,4'd0};
        vt[5]  = '{1'b1, 1'b1,1'b0,32'h100,32'h0,4'h0, 1'b1,32'h200,32'h0,4'h0, 32'h0, 1'b1,1'b0,1'b1, 32'h100,32'h0,4'h0, 1'b0,1'b0,4'd0};
        vt[6]  = '{1'b1, 1'b1,1'b0,32'h100,32'h0,4'h0, 1'b1,32'h200,32'h0,4'h0, 32'h0, 1'b0,1'b1,1'b1, 32'h200,32'h0,4'h0, 1'b1,1'b0,4'd1};
        vt[7]  = '{1'b1, 1'b1,1'b0,32'h100,32'h0,4'h0, 1'b1,32'h200,32'h0,4'h0, 32'h0, 1'b1,1'b0,1'b1, 32'h100,32'h0,4'h0, 1'b0,1'b1,4'd2};
        vt[8]  = '{1'b1, 1'b1,1'b0,32'h100,32'h0,4'h0, 1'b1,32'h200,32'h0,4'h0, 32'h0, 1'b0,1'b1,1'b1, 32'h200,32'h0,4'h0, 1'b1,1'b0,4'd3};
        vt[9]  = '{1'b1, 1'b1,1'b0,32'h100,32'h0,4'h0, 1'b1,32'h200,32'h0,4'h0, 32'h0, 1'b1,1'b0,1'b1, 32'h100,32'h0,4'h0, 1'b0,1'b1,4'd4};
        vt[10] = '{1'b1, 1'b1,1'b0,32'h100,32'h0,4'h0, 1'b1,32'h200,32'h0,4'h0, 32'h0, 1'b0,1'b1,1'b1, 32'h200,32'h0,4'h0, 1'b1,1'b0,4'd5};
        vt[11] = '{1'b1, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,32'h0,4'h0, 32'h1234_5678, 1'b0,1'b0,1'b0, 32'h0,32'h0,4'h0, 1'b0,1'b1,4'd6};
        vt[12] = '{1'b1, 1'b1,1'b1,32'h300,32'h3,4'hF, 1'b1,32'h400,32'h4,4'h3, 32'h0, 1'b1,1'b0,1'b0, 32'h300,32'h3,4'hF, 1'b0,1'b0,4'd6};
        vt[13] = '{1'b1, 1'b1,1'b1,32'h300,32'h3,4'hF, 1'b1,32'h400,32'h4,4'h3, 32'h0, 1'b1,1'b0,1'b0, 32'h300,32'h3,4'hF, 1'b0,1'b0,4'd7};
        vt[14] = '{1'b1, 1'b1,1'b1,32'h300,32'h3,4'hF, 1'b1,32'h400,32'h4,4'h3, 32'h0, 1'b1,1'b0,1'b0, 32'h300,32'h3,4'hF, 1'b0,1'b0,4'd8};
        vt[15] = '{1'b1, 1'b1,1'b1,32'h300,32'h3,4'hF, 1'b1,32'h400,32'h4,4'h3, 32'h0, 1'b1,1'b0,1'b0, 32'h300,32'h3,4'hF, 1'b0,1'b0,4'd9};
        vt[16] = '{1'b1, 1'b1,1'b1,32'h300,32'h3,4'hF, 1'b1,32'h400,32'h4,4'h3, 32'h0, 1'b0,1'b1,1'b0, 32'h400,32'h4,4'h3, 1'b0,1'b0,4'd10};
        vt[17] = '{1'b1, 1'b1,1'b1,32'h300,32'h3,4'hF, 1'b1,32'h400,32'h4,4'h3, 32'h0, 1'b1,1'b0,1'b0, 32'h300,32'h3,4'hF, 1'b0,1'b0,4'd11};
        vt[18] = '{1'b1, 1'b1,1'b0,32'h300,32'h3,4'hF, 1'b1,32'h400,32'h4,4'h3, 32'h0, 1'b1,1'b0,1'b0, 32'h300,32'h3,4'hF, 1'b0,1'b0,4'd12};
        vt[19] = '{1'b1, 1'b1,1'b0,32'h300,32'h3,4'hF, 1'b1,32'h400,32'h4,4'h3, 32'h0, 1'b0,1'b1,1'b0, 32'h400,32'h4,4'h3, 1'b0,1'b0,4'd13};
        vt[20] = '{1'b1, 1'b1,1'b1,32'h300,32'h3,4'hF, 1'b0,32'h400,32'h4,4'h3, 32'h0, 1'b1,1'b0,1'b0, 32'h300,32'h3,4'hF, 1'b0,1'b0,4'd14};
        vt[21] = '{1'b1, 1'b0,1'b0,32'h300,32'h3,4'hF, 1'b1,32'h400,32'h4,4'h3, 32'h0, 1'b0,1'b0,1'b0, 32'h0,32'h0,4'h0, 1'b0,1'b0,4'd14};
        vt[22] = '{1'b1, 1'b1,1'b0,32'h300,32'h3,4'hF, 1'b1,32'h400,32'h4,4'h3, 32'h0, 1'b1,1'b0,1'b0, 32'h300,32'h3,4'hF, 1'b0,1'b0,4'd15};
        vt[23] = '{1'b1, 1'b0,1'b0,32'h300,32'h3,4'hF, 1'b1,32'h400,32'h4,4'h3, 32'h0, 1'b0,1'b1,1'b0, 32'h400,32'h4,4'h3, 1'b0,1'b0,4'd15};
        vt[24] = '{1'b1, 1'b1,1'b0,32'h300,32'h3,4'hF, 1'b1,32'h400,32'h4,4'h3, 32'h0, 1'b1,1'b0,1'b0, 32'h300,32'h3,4'hF, 1'b0,1'b0,4'd15};
        vt[25] = '{1'b0, 1'b1,1'b0,32'h300,32'h3,4'hF, 1'b1,32'h400,32'h4,4'h3, 32'h0, 1'b0,1'b0,1'b0, 32'h0,32'h0,4'h0, 1'b0,1'b0,4'd15};
        vt[26] = '{1'b1, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,32'h0,4'h0, 32'h0, 1'b0,1'b0,1'b0, 32'h0,32'h0,4'h0, 1'b0,1'b0,4'd0};

        m1_if.lock = 1'b0;
        rst_n      = 1'b0;
        idle();
        repeat (2) @(posedge clk);

        // Table: inputs applied on the falling edge, outputs sampled 1 ns later
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vt[i]);
            #1;
            n_vec++;
            check($sformatf("v%0d.m0_gnt", i), 32'(m0_if.gnt), 32'(vt[i].g0));
            check($sformatf("v%0d.m1_gnt", i), 32'(m1_if.gnt), 32'(vt[i].g1));
            check($sformatf("v%0d.s_ren", i), 32'(s_ren), 32'(vt[i].ren));
            check($sformatf("v%0d.s_addr", i), s_addr, vt[i].saddr);
            check($sformatf("v%0d.s_wdata", i), s_wdata, vt[i].swd);
            check($sformatf("v%0d.s_wenable", i), 32'(s_wenable), 32'(vt[i].swe));
            check($sformatf("v%0d.m0_rvalid", i), 32'(m0_if.rvalid), 32'(vt[i].rv0));
            check($sformatf("v%0d.m1_rvalid", i), 32'(m1_if.rvalid), 32'(vt[i].rv1));
            check($sformatf("v%0d.m0_rdata", i), m0_if.rdata, vt[i].srd);
            check($sformatf("v%0d.m1_rdata", i), m1_if.rdata, vt[i].srd);
            check($sformatf("v%0d.conflict_cnt", i), 32'(conflict_cnt), 32'(vt[i].cnt));
        end

        // Lock held by m0 with m1 waiting: m1 must win on the fifth cycle
        @(negedge clk);
        idle();
        m0_if.req     = 1'b1;
        m0_if.lock    = 1'b1;
        m0_if.addr    = 32'h600;
        m0_if.wenable = 4'hF;
        m1_if.req     = 1'b1;
        m1_if.addr    = 32'h700;
        m1_if.wenable = 4'h1;
        got = 0;
        for (int c = 1; c <= 10; c++) begin
            #1;
            n_vec++;
            if (m1_if.gnt) begin
                got = c;
                break;
            end
            check($sformatf("lock_c%0d.m0_gnt", c), 32'(m0_if.gnt), 32'd1);
            @(negedge clk);
        end
        check("lock_release_cycle", 32'(got), 32'd5);

        // Reset in the cycle after a read grant drops the pending rvalid
        @(negedge clk);
        idle();
        m1_if.req  = 1'b1;
        m1_if.addr = 32'h500;
        #1;
        n_vec++;
        check("midrd.m1_gnt", 32'(m1_if.gnt), 32'd1);
        check("midrd.s_ren", 32'(s_ren), 32'd1);
        @(negedge clk);
        m1_if.req = 1'b0;
        rst_n     = 1'b0;
        #1;
        n_vec++;
        check("midrd.m1_rvalid_pre", 32'(m1_if.rvalid), 32'd1);
        check("midrd.m1_gnt_rst", 32'(m1_if.gnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        check("midrd.m1_rvalid_post", 32'(m1_if.rvalid), 32'd0);
        check("midrd.m0_rvalid_post", 32'(m0_if.rvalid), 32'd0);
        check("midrd.conflict_cnt", 32'(conflict_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
